// File: rtl/filtro_pb_seq.sv
// ============================================================================
// Module   : filtro_pb_seq
// Purpose  : Per-channel sliding-window ones counter with hysteresis decision,
//            sampled on the rising edge of a strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module filtro_pb_seq #(
    parameter int SAMPLES = 2,
    parameter int OSF     = 8,
    parameter int CH      = 1,
    parameter int TH_HI   = 10,
    parameter int TH_LO   = 6,
    localparam int WIN    = SAMPLES * OSF,
    localparam int CW     = $clog2(WIN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            P,
    input  logic [CH-1:0]   DataIn,
    input  logic            Clear,
    output logic [CH*CW-1:0] DataOut,
    output logic [CH-1:0]   Decision,
    output logic            Valid,
    output logic            Primed
);

    localparam logic [CW-1:0] WIN_C   = CW'(WIN);
    localparam logic [CW-1:0] TH_HI_C = CW'(TH_HI);
    localparam logic [CW-1:0] TH_LO_C = CW'(TH_LO);

    generate
        if (!(TH_LO >= 0 && TH_LO < TH_HI && TH_HI <= WIN && CH >= 1)) begin : g_bad_params
            $error("filtro_pb_seq: illegal parameters (need 0 <= TH_LO < TH_HI <= WIN, CH >= 1)");
        end
    endgenerate

    logic            p_d;
    logic            sample;
    logic            valid_q;
    logic [CW-1:0]   fill;

    assign sample = P & ~p_d;

    // p_d keeps tracking P even while Clear is asserted, so a held strobe
    // cannot produce a late sample once Clear drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_d     <= 1'b0;
            valid_q <= 1'b0;
            fill    <= '0;
        end else begin
            p_d <= P;
            if (Clear) begin
                valid_q <= 1'b0;
                fill    <= '0;
            end else begin
                valid_q <= sample;
                if (sample && (fill != WIN_C))
                    fill <= fill + CW'(1);
            end
        end
    end

    assign Valid  = valid_q;
    assign Primed = (fill == WIN_C);

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            logic [WIN-1:0] window;
            logic [CW-1:0]  count;
            logic [CW-1:0]  next_count;
            logic           dec;
            logic           next_dec;

            // Incremental update: the count never leaves 0..WIN because it
            // always equals the popcount of the window.
            always_comb begin
                next_count = count + CW'(DataIn[c]) - CW'(window[WIN-1]);
                next_dec   = dec;
                if (next_count >= TH_HI_C)
                    next_dec = 1'b1;
                else if (next_count <= TH_LO_C)
                    next_dec = 1'b0;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    window <= '0;
                    count  <= '0;
                    dec    <= 1'b0;
                end else if (Clear) begin
                    window <= '0;
                    count  <= '0;
                    dec    <= 1'b0;
                end else if (sample) begin
                    window <= (window << 1) | WIN'(DataIn[c]);
                    count  <= next_count;
                    dec    <= next_dec;
                end
            end

            assign DataOut[c*CW +: CW] = count;
            assign Decision[c]         = dec;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_filtro_pb_seq.sv
// ============================================================================
// Module   : tb_filtro_pb_seq
// Purpose  : Scoreboard bench for filtro_pb_seq (CH=1 and CH=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filtro_pb_seq;

    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            P = 1'b0;
    logic            Clear = 1'b0;
    logic [0:0]      din_a = '0;
    logic [1:0]      din_b = '0;

    logic [CW-1:0]   out_a;
    logic [0:0]      dec_a;
    logic            val_a;
    logic            pri_a;
    logic [2*CW-1:0] out_b;
    logic [1:0]      dec_b;
    logic            val_b;
    logic            pri_b;

    filtro_pb_seq dut_a (
        .clk(clk), .rst(rst), .P(P), .DataIn(din_a), .Clear(Clear),
        .DataOut(out_a), .Decision(dec_a), .Valid(val_a), .Primed(pri_a)
    );

    filtro_pb_seq #(.CH(2)) dut_b (
        .clk(clk), .rst(rst), .P(P), .DataIn(din_b), .Clear(Clear),
        .DataOut(out_b), .Decision(dec_b), .Valid(val_b), .Primed(pri_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] c0;
        logic [CW-1:0] c1;
        logic          dec0;
        logic          dec1;
        logic          primed;
    } exp_t;

    exp_t sb[$];

    int n_vec  = 0;
    int n_fail = 0;
    int valid_seen = 0;

    logic [15:0] mwin0, mwin1;
    logic        mdec0, mdec1;
    logic        prev_p;
    int          mfill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mwin0 = '0; mwin1 = '0; mdec0 = 1'b0; mdec1 = 1'b0; mfill = 0; prev_p = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic clr, input logic x0, input logic x1);
        int   n0, n1;
        exp_t e;
        if (clr) begin
            mwin0 = '0; mwin1 = '0; mdec0 = 1'b0; mdec1 = 1'b0; mfill = 0;
        end else if (p && !prev_p) begin
            mwin0 = {mwin0[14:0], x0};
            mwin1 = {mwin1[14:0], x1};
            n0 = $countones(mwin0);
            n1 = $countones(mwin1);
            if (n0 >= 10) mdec0 = 1'b1; else if (n0 <= 6) mdec0 = 1'b0;
            if (n1 >= 10) mdec1 = 1'b1; else if (n1 <= 6) mdec1 = 1'b0;
            if (mfill < 16) mfill++;
            e.c0 = CW'(n0); e.c1 = CW'(n1);
            e.dec0 = mdec0; e.dec1 = mdec1; e.primed = (mfill == 16);
            sb.push_back(e);
        end
        prev_p = p;
    endtask

    // Inputs are applied at a falling edge and held for one full clock.
    task automatic cycle(input logic p, input logic clr, input logic x0, input logic x1);
        P = p; Clear = clr; din_a = x0; din_b = {x1, x0};
        model_step(p, clr, x0, x1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("valid_ch1_vs_ch2", 32'(val_b), 32'(val_a));
            if (val_a) begin
                valid_seen++;
                check("valid_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dataout_a",  32'(out_a), 32'(e.c0));
                    check("decision_a", 32'(dec_a), 32'(e.dec0));
                    check("primed_a",   32'(pri_a), 32'(e.primed));
                    check("dataout_b",  32'(out_b), 32'({e.c1, e.c0}));
                    check("decision_b", 32'(dec_b), 32'({e.dec1, e.dec0}));
                    check("primed_b",   32'(pri_b), 32'(e.primed));
                end
            end
        end
    end

    initial begin
        int vs;

        // Reset asserted between edges must clear outputs without a clock.
        #3;
        rst = 1'b1; P = 1'b1; din_a = 1'b1; din_b = 2'b11;
        #1;
        check("rst_async_dataout", 32'(out_a), 32'd0);
        check("rst_async_valid",   32'(val_a), 32'd0);
        check("rst_async_primed",  32'(pri_a), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_dataout_a", 32'(out_a), 32'd0);
        check("rst_hold_dataout_b", 32'(out_b), 32'd0);
        check("rst_hold_decision",  32'(dec_b), 32'd0);
        check("rst_hold_valid",     32'(val_b), 32'd0);
        model_reset();
        rst = 1'b0;
        cycle(1, 0, 1, 1);
        cycle(0, 0, 0, 0);
        #1;
        check("rst_first_sample_valids", 32'(valid_seen), 32'd1);
        check("rst_first_sample_drained", 32'(sb.size()), 32'd0);

        // Strobe held high for five cycles yields one sample.
        vs = valid_seen;
        repeat (5) cycle(1, 0, 1, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        #1;
        check("edge_one_valid", 32'(valid_seen - vs), 32'd1);
        check("edge_dataout",   32'(out_a), 32'd2);

        // Fill with ones: decision rises at 10, primed at 16.
        cycle(0, 1, 0, 0);
        #1;
        check("clear_dataout", 32'(out_a), 32'd0);
        vs = valid_seen;
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 1, 0);
            cycle(0, 0, 1, 0);
        end
        #1;
        check("fill_valids",   32'(valid_seen - vs), 32'd16);
        check("fill_dataout",  32'(out_a), 32'd16);
        check("fill_decision", 32'(dec_a), 32'd1);
        check("fill_primed",   32'(pri_a), 32'd1);

        // Drain with zeros: decision holds through 7, falls at 6.
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 0, 0);
            cycle(0, 0, 0, 0);
        end
        #1;
        check("drain_dataout",  32'(out_a), 32'd0);
        check("drain_decision", 32'(dec_a), 32'd0);
        check("drain_primed",   32'(pri_a), 32'd1);

        // Clear coinciding with a strobe edge wins.
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 1, 1);
            cycle(0, 0, 1, 1);
        end
        #1;
        check("preclear_decision", 32'(dec_b), 32'd3);
        vs = valid_seen;
        cycle(1, 1, 1, 1);
        #1;
        check("clrprio_valid",    32'(val_a), 32'd0);
        check("clrprio_dataout",  32'(out_b), 32'd0);
        check("clrprio_decision", 32'(dec_b), 32'd0);
        check("clrprio_primed",   32'(pri_a), 32'd0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        #1;
        check("clrprio_no_valid", 32'(valid_seen - vs), 32'd0);

        // Independent channels: ch0 all ones, ch1 alternating.
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 1, logic'(i % 2 == 0));
            cycle(0, 0, 0, 0);
        end
        #1;
        check("multi_dataout",  32'(out_b), 32'({5'd8, 5'd16}));
        check("multi_decision", 32'(dec_b), 32'd1);
        check("multi_primed",   32'(pri_b), 32'd1);

        cycle(0, 0, 0, 0);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/filtro_pb_seq.md
FILTRO_PB_SEQ -- requirements
Module: filtro_pb_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SAMPLES, 2: symbols per window
- OSF, 8: oversampling factor; window length WIN = SAMPLES*OSF
- CH, 1: independent channels
- TH_HI, 10: decision set threshold
- TH_LO, 6: decision clear threshold
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on its rising edge
- rst, in, 1: asynchronous active-high reset
- P, in, 1: sample strobe, level input, edge-detected internally
- DataIn, in, CH: one oversampled bit per channel
- Clear, in, 1: synchronous flush
- DataOut, out, CH*CW with CW = $clog2(WIN)+1: per-channel ones count; channel c occupies bits [c*CW +: CW]
- Decision, out, CH: per-channel hysteresis output
- Valid, out, 1: one-cycle pulse marking new DataOut/Decision
- Primed, out, 1: window completely filled since the last reset or Clear
REQ-003 Parameter legality SHALL be TH_LO < TH_HI <= WIN and CH >= 1; illegal values SHALL be flagged by an elaboration-time check.

Function
REQ-004 The block SHALL register P every cycle (p_d) and take a sample only in a cycle where P=1 and p_d=0; P held high for N cycles SHALL yield exactly one sample.
REQ-005 On a sample, each channel SHALL shift DataIn[c] into bit 0 of its WIN-bit window and discard bit WIN-1.
REQ-006 On a sample, each channel count SHALL update as count + new bit - discarded bit. The count SHALL always equal the popcount of the window and SHALL lie in the range 0..WIN, with no wrap.
REQ-007 DataOut SHALL be the registered count and SHALL change only on the sampling edge, so the new value is visible in the cycle after the P rising edge is seen.
REQ-008 Valid SHALL be 1 for exactly the one cycle following each sampling edge, and 0 otherwise.
REQ-009 Decision[c] SHALL be evaluated on the updated count:
- set to 1 if count >= TH_HI
- cleared to 0 if count <= TH_LO
- otherwise held
REQ-010 A fill counter SHALL increment once per sample, saturate at WIN, and assert Primed from the cycle its value reaches WIN until the next reset or Clear.
REQ-011 Valid and Decision SHALL operate regardless of Primed; Primed is status only.
REQ-012 Clear=1 at a clock edge SHALL zero all windows, counts, Decision and the fill counter, and deassert Primed and Valid.
REQ-013 If Clear and a P edge coincide, Clear SHALL win: the sample is discarded and no Valid is produced. p_d SHALL still update.
REQ-014 Channels SHALL share P, Clear and Valid but SHALL keep fully independent windows, counts and decisions.

Reset
REQ-015 rst=1 SHALL immediately, without waiting for clk, set windows, counts, DataOut, Decision, Valid, Primed, the fill counter and p_d to 0.
REQ-016 Because p_d resets to 0, P=1 at the first edge after rst release SHALL count as a sample.
REQ-017 rst asserted mid-operation SHALL abandon any pending Valid; no output SHALL pulse on reset release.

Verification
REQ-018 The bench SHALL use defaults unless stated, and SHALL cover these scenarios:
- Reset check: rst pulse with P=1, DataIn=1 -> all outputs 0 while rst=1; first edge after release gives DataOut=1, Valid pulse.
- Edge detection: P held high 5 cycles, DataIn=1 -> exactly one sample; DataOut +1; exactly one Valid cycle.
- Fill and hysteresis up: 16 P pulses with DataIn=1 -> DataOut 1..16 with one Valid each; Decision rises on count 10; Primed rises on the 16th sample.
- Hysteresis down: then 16 pulses with DataIn=0 -> DataOut 15..0; Decision holds 1 through count 7 and falls at count 6; Primed stays 1.
- Clear priority: Clear=1 in the same cycle as a P edge with DataIn=1 -> DataOut=0, Decision=0, Primed=0, no Valid.
- Multichannel: CH=2, ch0 all ones, ch1 alternating 1/0, 16 samples -> ch0 count 16, Decision 1; ch1 count 8, Decision 0 (held in band).
